// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, requester IDs
// and a counter-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arbState_t;

  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} reqId_t;

  // Width of a counter that must hold 0..maxVal (at least one bit).
  function automatic int cntW(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection between fetch and data requesters, with the starvation
// counter that hands the fetch side a guaranteed slot.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int CW           = cntW(STARVE_LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic iReq,
  input  logic dReq,
  input  logic grant,
  output logic winD
);

  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starveCnt;

  // Data wins ties unless the fetch has waited through LIM data grants.
  assign winD = dReq && !(iReq && (starveCnt == LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt <= '0;
    end else if (!iReq) begin
      starveCnt <= '0;
    end else if (grant) begin
      if (!winD)                  starveCnt <= '0;
      else if (starveCnt != LIM)  starveCnt <= starveCnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: latches the winner's request,
// issues one memory strobe, waits for completion (with timeout) and pulses done.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy,
  output logic              err
);

  localparam int             TW       = cntW(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  arbState_t     state, nxt;
  reqId_t        lWho;
  logic [TW-1:0] tmoCnt;
  logic          grant, winD, tmoHit, errSet;

  arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) uPick (
    .clk   (clk),
    .rst   (rst),
    .iReq  (i_req),
    .dReq  (d_req),
    .grant (grant),
    .winD  (winD)
  );

  always_comb begin
    nxt    = state;
    grant  = 1'b0;
    tmoHit = (state == WAIT) && !m_ready && (tmoCnt == TMO_LAST);
    case (state)
      IDLE:  if (i_req || d_req) begin
               grant = 1'b1;
               nxt   = ISSUE;
             end
      ISSUE: nxt = WAIT;
      WAIT:  if (m_ready)    nxt = RESP;
             else if (tmoHit) nxt = IDLE;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // A completion outside WAIT is a protocol violation; it only flags.
    errSet = (m_ready && (state != WAIT)) || tmoHit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lWho    <= REQ_I;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      tmoCnt  <= '0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state  <= nxt;
      tmoCnt <= (state == WAIT) ? tmoCnt + TW'(1) : '0;
      if (errSet) err <= 1'b1;
      if (grant) begin
        lWho    <= winD ? REQ_D : REQ_I;
        m_wr    <= winD ? d_wr : 1'b0;
        m_addr  <= winD ? d_addr : i_addr;
        m_wdata <= winD ? d_wdata : '0;
      end
      if ((state == WAIT) && m_ready && !m_wr) rdata <= m_rdata;
    end
  end

  assign m_en      = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign i_done    = (state == RESP) && (lWho == REQ_I);
  assign d_done    = (state == RESP) && (lWho == REQ_D);
  assign stall_if  = i_req & ~i_done;
  assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued when requests
// are driven and checked against m_en strobes and done pulses.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_done, d_done, stall_if, stall_mem;
  logic [15:0] rdata, m_addr, m_wdata, m_rdata;
  logic        m_en, m_wr, m_ready, busy, err;

  logic        memRdy, spurRdy, memMute;
  int          memDelay;
  logic [15:0] memData, lastRd;
  int          total = 0, bad = 0;

  typedef struct {
    logic        isD;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rd;
    bit          expectDone;
  } item_t;

  item_t expQ[$];
  item_t doneQ[$];

  assign m_ready = memRdy | spurRdy;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic isD, input logic [15:0] addr, input logic wr,
                      input logic [15:0] wdata, input logic [15:0] rd, input bit expectDone);
    item_t it;
    it.isD = isD; it.addr = addr; it.wr = wr; it.wdata = wdata;
    it.rd = rd; it.expectDone = expectDone;
    expQ.push_back(it);
  endtask

  task automatic waitDone(input int maxCyc, output logic gd, output logic gi);
    gd = 1'b0; gi = 1'b0;
    for (int c = 0; c < maxCyc; c++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        gd = d_done; gi = i_done;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  // Memory model: answers each strobe memDelay cycles later unless muted.
  initial begin
    memRdy = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && m_en && !memMute) begin
        repeat (memDelay) @(posedge clk);
        #1; memRdy = 1'b1; m_rdata = memData;
        @(posedge clk);
        #1; memRdy = 1'b0;
      end
    end
  end

  // Monitor: match strobes and done pulses against the expected queues.
  initial begin
    item_t it;
    lastRd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        lastRd = '0;
      end else begin
        if (m_en) begin
          if (expQ.size() == 0) chk("unexp_grant", 1, 0);
          else begin
            it = expQ.pop_front();
            chk("gnt_addr", m_addr, it.addr);
            chk("gnt_wr", m_wr, it.wr);
            chk("gnt_wdata", m_wdata, it.wdata);
            if (it.expectDone) doneQ.push_back(it);
          end
        end
        if (i_done || d_done) begin
          if (doneQ.size() == 0) chk("unexp_done", 1, 0);
          else begin
            it = doneQ.pop_front();
            chk("done_isD", d_done, it.isD);
            chk("done_one", i_done & d_done, 0);
            if (!it.wr) lastRd = it.rd;
            chk("done_rdata", rdata, lastRd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic gd, gi;
    rst = 1'b0; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    spurRdy = 0; memMute = 0; memDelay = 1; memData = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_err", err, 0);
    chk("rst_men", m_en, 0);    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", m_addr, 0); chk("rst_mwr", m_wr, 0);
    chk("rst_mwdata", m_wdata, 0);
    chk("rst_idone", i_done, 0); chk("rst_ddone", d_done, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single fetch with minimum latency
    memData = 16'hBEEF; memDelay = 1;
    push(0, 16'h0010, 0, 16'h0, 16'hBEEF, 1);
    i_req = 1; i_addr = 16'h0010;
    @(negedge clk);
    chk("f_n_men", m_en, 0); chk("f_stall_if", stall_if, 1); chk("f_stall_mem", stall_mem, 0);
    @(negedge clk);
    chk("f_n1_men", m_en, 1); chk("f_n1_busy", busy, 1);
    @(negedge clk);
    chk("f_n2_men", m_en, 0); chk("f_n2_idone", i_done, 0);
    @(negedge clk);
    chk("f_n3_idone", i_done, 1); chk("f_n3_ddone", d_done, 0);
    chk("f_n3_rdata", rdata, 16'hBEEF); chk("f_n3_stall_if", stall_if, 0);
    @(posedge clk); #1 i_req = 0;
    @(negedge clk);
    chk("f_idle_busy", busy, 0); chk("f_idone_once", i_done, 0);

    // Tie: data first, inputs changed mid-transaction, then fetch
    @(posedge clk); #1;
    memData = 16'hCAFE;
    i_req = 1; i_addr = 16'h0044;
    d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    push(1, 16'h0200, 1, 16'h1234, 16'h0, 1);
    push(0, 16'h0044, 0, 16'h0, 16'hCAFE, 1);
    @(negedge clk); @(negedge clk);
    d_addr = 16'hFFFF; d_wdata = 16'h0; d_wr = 0;
    waitDone(40, gd, gi);
    chk("tie_first_d", gd, 1);
    chk("tie_hold_addr", m_addr, 16'h0200); chk("tie_hold_wr", m_wr, 1);
    chk("tie_hold_wdata", m_wdata, 16'h1234); chk("tie_store_rdata", rdata, 16'hBEEF);
    @(posedge clk); #1 d_req = 0;
    waitDone(40, gd, gi);
    chk("tie_then_i", gi, 1);
    @(posedge clk); #1 i_req = 0;

    // Starvation: three data grants, then the fetch
    @(negedge clk);
    @(posedge clk); #1;
    memDelay = 3; memData = 16'h1111;
    i_req = 1; i_addr = 16'h0300;
    d_req = 1; d_wr = 0; d_addr = 16'h0400;
    for (int k = 0; k < 3; k++) push(1, 16'h0400, 0, 16'h0, 16'h1111, 1);
    push(0, 16'h0300, 0, 16'h0, 16'h1111, 1);
    for (int k = 0; k < 3; k++) begin
      waitDone(40, gd, gi);
      chk("stv_d", gd, 1);
    end
    waitDone(40, gd, gi);
    chk("stv_i", gi, 1);
    chk("stv_cnt", 32'(dut.uPick.starveCnt), 0);
    @(posedge clk); #1 i_req = 0; d_req = 0;

    // Timeout: no m_ready, request dropped mid-transaction
    @(negedge clk);
    @(posedge clk); #1;
    memMute = 1; d_req = 1; d_wr = 0; d_addr = 16'h0500;
    push(1, 16'h0500, 0, 16'h0, 16'h0, 0);
    @(negedge clk);
    @(negedge clk); chk("to_men", m_en, 1);
    @(posedge clk); #1 d_req = 0;
    repeat (15) @(negedge clk);
    chk("to_w15_busy", busy, 1); chk("to_w15_err", err, 0);
    @(negedge clk);
    chk("to_err", err, 1); chk("to_busy", busy, 0); chk("to_rdata", rdata, 16'h1111);
    repeat (3) @(negedge clk);
    chk("to_stay_idle", busy, 0);

    // Reset while in WAIT, then a normal fetch dropped mid-transaction
    @(posedge clk); #1;
    i_req = 1; i_addr = 16'h0700;
    push(0, 16'h0700, 0, 16'h0, 16'h0, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rw_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rw_rst_busy", busy, 0); chk("rw_rst_err", err, 0);
    chk("rw_rst_idone", i_done, 0); chk("rw_rst_maddr", m_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1; memMute = 0; memDelay = 2; memData = 16'h5A5A; i_addr = 16'h0600;
    push(0, 16'h0600, 0, 16'h0, 16'h5A5A, 1);
    @(negedge clk); chk("rw_idle", busy, 0);
    @(negedge clk); chk("rw_men", m_en, 1); chk("rw_maddr", m_addr, 16'h0600);
    @(posedge clk); #1 i_req = 0;
    waitDone(40, gd, gi);
    chk("rw_idone", gi, 1); chk("rw_rdata", rdata, 16'h5A5A);

    // Spurious m_ready in IDLE sets a sticky err
    @(posedge clk); #1 spurRdy = 1;
    @(posedge clk); #1 spurRdy = 0;
    @(negedge clk);
    chk("sp_err", err, 1); chk("sp_busy", busy, 0);
    @(posedge clk); #1;
    memDelay = 1; memData = 16'h7777; i_req = 1; i_addr = 16'h0800;
    push(0, 16'h0800, 0, 16'h0, 16'h7777, 1);
    waitDone(40, gd, gi);
    chk("sp_idone", gi, 1);
    @(posedge clk); #1 i_req = 0;
    repeat (2) @(negedge clk);
    chk("sp_err_sticky", err, 1);

    chk("expq_empty", expQ.size(), 0);
    chk("doneq_empty", doneQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive data grants allowed while a fetch is pending.
REQ-004 SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before an error.
REQ-005 SHALL have the following ports, with clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held until d_done.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle data completion pulse.
- rdata  out  DATA_W  read data of the last completed access.
- stall_if  out  1  i_req & ~i_done.
- stall_mem  out  1  d_req & ~d_done.
- m_en  out  1  memory start strobe.
- m_wr  out  1  memory write.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid with m_ready.
- m_ready  in  1  one-cycle memory completion pulse.
- busy  out  1  high when the FSM is not IDLE.
- err  out  1  sticky error flag.

Function
REQ-006 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-007 In IDLE, if any request is present, SHALL select a winner, latch its addr/wr/wdata, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-008 In ISSUE, SHALL drive m_en=1 for exactly one cycle with the latched values, then go to WAIT.
REQ-009 In WAIT, on m_ready, SHALL capture m_rdata into rdata (loads only) and go to RESP.
REQ-010 In RESP, SHALL pulse the winner's done for one cycle, then return to IDLE.
REQ-011 Minimum latency SHALL be 4 cycles from request to done (req sampled in IDLE at N, m_en at N+1, m_ready at N+2, done at N+3).
REQ-012 Priority SHALL go to data on a tie, except that the fetch SHALL win when starve_cnt == STARVE_LIMIT.
REQ-013 starve_cnt SHALL increment when data wins while i_req=1, clear when the fetch is granted or i_req=0, and saturate at STARVE_LIMIT.
REQ-014 m_addr, m_wr and m_wdata SHALL hold their latched values from ISSUE through RESP; a requester changing its inputs mid-transaction SHALL have no effect on them.
REQ-015 If a requester drops req mid-transaction, the access SHALL still complete and done SHALL still pulse.
REQ-016 A req held high during RESP SHALL NOT be re-granted until IDLE, the cycle after done.
REQ-017 m_ready in IDLE, ISSUE or RESP SHALL set err and SHALL otherwise be ignored.
REQ-018 If WAIT lasts TIMEOUT cycles without m_ready, SHALL set err, return to IDLE and SHALL NOT pulse done.
REQ-019 rdata SHALL be unchanged by stores and by timed-out accesses.
REQ-020 stall_if and stall_mem SHALL be combinational.

Reset
REQ-021 On rst low, SHALL immediately enter IDLE with the following values at 0: starve_cnt, timeout counter, err, rdata, m_en, m_wr, m_addr, m_wdata, i_done, d_done and busy.
REQ-022 Reset mid-transaction SHALL abandon the access with no done pulse.
REQ-023 SHALL be back in IDLE, able to grant, on the first clk edge after rst deasserts.

Structure
REQ-024 The FSM state encoding and the requester IDs (REQ_I, REQ_D) SHALL live in the shared package mem_arb_pkg.
REQ-025 A sub-module arb_pick SHALL contain the combinational winner selection plus the starve_cnt register.
REQ-026 The FSM, latches and counters SHALL reside in mem_arbiter.

Verification
REQ-027 Single fetch: i_req, i_addr=0x0010, m_ready 1 cycle after m_en, m_rdata=0xBEEF -> m_en at N+1, i_done at N+3, rdata=0xBEEF, d_done=0.
REQ-028 Tie: i_req and d_req high together, d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> data granted first with m_wr=1 and m_addr=0x0200; fetch granted in the next IDLE.
REQ-029 Starvation: i_req held while d_req is re-issued continuously -> 3 data grants, then a fetch grant, then starve_cnt=0.
REQ-030 Timeout: request issued and m_ready never asserted -> err=1 after 15 WAIT cycles, no done pulse, busy=0 on the next cycle.
REQ-031 Spurious m_ready in IDLE -> err=1; err remains set until rst is asserted.
REQ-032 Reset in WAIT: rst low for 1 cycle -> busy=0 and no done pulse; a new i_req is then granted normally.
